// File: rtl/ibuf_pkg.sv
// Shared widths and the queued entry type for the instruction buffer.
package ibuf_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

    // One queued fetch result; pc sits in the upper bits of the 96-bit word.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/ibuf_mem.sv
// Entry storage for ibuf: DEPTH register slots, one write port, one async read port.
module ibuf_mem
    import ibuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  entry_t           wdata,
    input  logic [PTR_W-1:0] raddr,
    output entry_t           rdata
);

    entry_t mem [DEPTH];

    // Storage is deliberately left out of reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ibuf.sv
// Instruction buffer between fetch and decode: FIFO of {pc, instr} with hold and flush.
// Define IBUF_BYPASS_EN to let an empty buffer forward the fetch input straight to decode.
module ibuf
    import ibuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [XLEN-1:0]    i_pc,
    input  logic               i_instr_valid,
    input  logic               i_flush,
    output logic               o_hold,
    output logic [INSTR_W-1:0] o_instr,
    output logic [XLEN-1:0]    o_pc,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [PTR_W:0]     o_count,
    output logic               o_overflow
);

    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] HOLD_LVL = (PTR_W+1)'(DEPTH - 1);

    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic [PTR_W:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic           full, empty, push, pop;
    entry_t         wr_entry, rd_entry;

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = ~empty & i_ready & ~i_flush;

    assign wr_entry.pc    = i_pc;
    assign wr_entry.instr = i_instr;

`ifdef IBUF_BYPASS_EN
    logic bypass;

    // An empty buffer hands the fetch input straight to decode; if decode
    // takes it this cycle it never touches the storage.
    assign bypass  = empty & i_instr_valid & ~i_flush;
    assign push    = i_instr_valid & ~full & ~i_flush & ~(bypass & i_ready);
    assign o_valid = ~empty | bypass;
    assign o_instr = ~empty ? rd_entry.instr : (bypass ? i_instr : '0);
    assign o_pc    = ~empty ? rd_entry.pc    : (bypass ? i_pc    : '0);
`else
    assign push    = i_instr_valid & ~full & ~i_flush;
    assign o_valid = ~empty;
    assign o_instr = empty ? '0 : rd_entry.instr;
    assign o_pc    = empty ? '0 : rd_entry.pc;
`endif

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (i_flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
    end

    assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

    // Hold is taken from the next-state count so fetch sees it one cycle early.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_hold     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            o_count    <= count_nxt;
            o_hold     <= (count_nxt >= HOLD_LVL);
            o_overflow <= i_instr_valid & full & ~i_flush;
        end
    end

    ibuf_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[PTR_W-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[PTR_W-1:0]),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_ibuf.sv
// Self-checking bench for ibuf: queue-based reference model, directed scenarios, random traffic.
module tb_ibuf;
    import ibuf_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef IBUF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [INSTR_W-1:0] i_instr;
    logic [XLEN-1:0]    i_pc;
    logic               i_instr_valid;
    logic               i_flush;
    logic               i_ready;
    logic               o_hold;
    logic [INSTR_W-1:0] o_instr;
    logic [XLEN-1:0]    o_pc;
    logic               o_valid;
    logic [PTR_W:0]     o_count;
    logic               o_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    ibuf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr       (i_instr),
        .i_pc          (i_pc),
        .i_instr_valid (i_instr_valid),
        .i_flush       (i_flush),
        .o_hold        (o_hold),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_overflow    (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the buffer contents as a plain queue of entries.
    entry_t mq[$];
    entry_t m_new;
    bit     m_ovf = 1'b0;
    bit     m_full;
    bit     m_take;

    always @(posedge clk) begin
        if (!rst_n || i_flush) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_take = BYPASS && (mq.size() == 0) && i_instr_valid && i_ready;
            m_ovf  = i_instr_valid && m_full;
            if (mq.size() > 0 && i_ready) void'(mq.pop_front());
            if (i_instr_valid && !m_full && !m_take) begin
                m_new.pc    = i_pc;
                m_new.instr = i_instr;
                mq.push_back(m_new);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, well away from the rising edge.
    always @(negedge clk) begin
        logic             e_valid;
        logic [XLEN-1:0]  e_pc;
        logic [INSTR_W-1:0] e_instr;
        #2;
        if (chk_en) begin
            if (mq.size() > 0) begin
                e_valid = 1'b1; e_pc = mq[0].pc; e_instr = mq[0].instr;
            end else if (BYPASS && i_instr_valid && !i_flush) begin
                e_valid = 1'b1; e_pc = i_pc; e_instr = i_instr;
            end else begin
                e_valid = 1'b0; e_pc = '0; e_instr = '0;
            end
            checkOutput("valid", 96'(o_valid), 96'(e_valid));
            checkOutput("instr", 96'(o_instr), 96'(e_instr));
            checkOutput("pc", 96'(o_pc), 96'(e_pc));
            checkOutput("count", 96'(o_count), 96'(mq.size()));
            checkOutput("hold", 96'(o_hold), 96'(mq.size() >= DEPTH - 1));
            checkOutput("overflow", 96'(o_overflow), 96'(m_ovf));
        end
    end

    task automatic applyStimulus(input bit rst, input bit v, input bit rdy, input bit fl,
                                 input logic [INSTR_W-1:0] ins, input logic [XLEN-1:0] pc);
        @(negedge clk);
        rst_n         = rst;
        i_instr_valid = v;
        i_ready       = rdy;
        i_flush       = fl;
        i_instr       = ins;
        i_pc          = pc;
    endtask

    initial begin
        rst_n = 1'b0; i_instr_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        i_instr = '0; i_pc = '0;
        applyStimulus(0, 0, 0, 0, '0, '0);
        applyStimulus(0, 0, 0, 0, '0, '0);
        chk_en = 1'b1;
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("rst_count", 96'(o_count), 96'd0);
        checkOutput("rst_valid", 96'(o_valid), 96'd0);
        checkOutput("rst_hold", 96'(o_hold), 96'd0);
        checkOutput("rst_ovf", 96'(o_overflow), 96'd0);

        // Basic fill with decode stalled.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h00A0_0013 + 32'(i), RESET_PC + 64'(4 * i));
            if (i == 3) begin
                #1;
                checkOutput("fill3_count", 96'(o_count), 96'd3);
                checkOutput("fill3_hold", 96'(o_hold), 96'd1);
                checkOutput("fill3_pc", 96'(o_pc), 96'(64'h8000_0000));
            end
        end
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("fill4_count", 96'(o_count), 96'd4);
        checkOutput("fill4_instr", 96'(o_instr), 96'(32'h00A0_0013));

        // Push while full is dropped and flagged once.
        applyStimulus(1, 1, 0, 0, 32'h0000_0013, 64'h0000_0BAD);
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("ovf_pulse", 96'(o_overflow), 96'd1);
        checkOutput("ovf_count", 96'(o_count), 96'd4);
        checkOutput("ovf_head", 96'(o_pc), 96'(64'h8000_0000));
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("ovf_clear", 96'(o_overflow), 96'd0);

        // Drain in order.
        repeat (4) applyStimulus(1, 0, 1, 0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("drain_valid", 96'(o_valid), 96'd0);
        checkOutput("drain_count", 96'(o_count), 96'd0);

        // Steady push+pop at count 2 across pointer wrap.
        for (int i = 0; i < 12; i++)
            applyStimulus(1, 1, (i >= 2), 0, 32'h0000_1000 + 32'(i), RESET_PC + 64'h100 + 64'(4 * i));
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("stream_count", 96'(o_count), 96'd2);
        checkOutput("stream_head", 96'(o_pc), 96'(64'h8000_0128));

        // Flush beats a simultaneous push and pop.
        repeat (2) applyStimulus(1, 0, 1, 0, '0, '0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 0, 0, 32'h0000_2000 + 32'(i), RESET_PC + 64'h200 + 64'(4 * i));
        applyStimulus(1, 1, 1, 1, 32'h0000_2FFF, 64'h0000_2FFF);
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("flush_count", 96'(o_count), 96'd0);
        checkOutput("flush_valid", 96'(o_valid), 96'd0);
        checkOutput("flush_hold", 96'(o_hold), 96'd0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 1, 0, 0, 32'h0000_3000 + 32'(i), RESET_PC + 64'h300 + 64'(4 * i));
        applyStimulus(0, 1, 0, 0, 32'h0000_3FFF, 64'h0000_3FFF);
        applyStimulus(1, 1, 0, 0, 32'h0050_0093, 64'hDEAD_0000);
        #1;
        checkOutput("mrst_count", 96'(o_count), 96'd0);
        checkOutput("mrst_hold", 96'(o_hold), 96'd0);
        applyStimulus(1, 0, 0, 0, '0, '0);
        #1;
        checkOutput("mrst_valid", 96'(o_valid), 96'd1);
        checkOutput("mrst_pc", 96'(o_pc), 96'(64'hDEAD_0000));
        applyStimulus(1, 0, 1, 0, '0, '0);

        // Empty buffer, push with decode ready.
        applyStimulus(1, 1, 1, 0, 32'h0010_0093, 64'h8000_0400);
        #1;
`ifdef IBUF_BYPASS_EN
        checkOutput("byp_valid", 96'(o_valid), 96'd1);
        checkOutput("byp_instr", 96'(o_instr), 96'(32'h0010_0093));
`else
        checkOutput("byp_valid", 96'(o_valid), 96'd0);
`endif
        applyStimulus(1, 0, 1, 0, '0, '0);
        #1;
`ifdef IBUF_BYPASS_EN
        checkOutput("byp_count", 96'(o_count), 96'd0);
        checkOutput("byp_after", 96'(o_valid), 96'd0);
`else
        checkOutput("byp_count", 96'(o_count), 96'd1);
        checkOutput("byp_instr", 96'(o_instr), 96'(32'h0010_0093));
`endif
        applyStimulus(1, 0, 0, 0, '0, '0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++)
            applyStimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 60),
                          ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 5),
                          $urandom, {$urandom, $urandom});
        repeat (6) applyStimulus(1, 0, 1, 0, '0, '0);
        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
